vram_bus_scheduler: RTL and testbench

Owns the PPU VRAM bus timing. A free-running 4-stage memory stager (address latch, settle, strobe, capture) divides the bus into slots. Each slot goes to either the render fetch pipeline or the CPU PPUDATA ($2007) port. The block drives the multiplexed address/data bus strobes, returns fetched data to the winning requester, and runs the CPU-side delayed read buffer.

---
 rtl/ppu_vram_pkg.sv | 28 ++
 rtl/vram_stager.sv | 41 ++++
 rtl/vram_bus_scheduler.sv | 155 +++++++++++++++
 tb/tb_vram_bus_scheduler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_vram_pkg.sv
// Shared types and constants for the PPU VRAM bus scheduler and its stager.
package ppu_vram_pkg;

    // Who owns the current four-stage bus slot.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RENDER = 2'd1,
        CPU    = 2'd2
    } slot_owner_t;

    // Stager positions within one slot.
    localparam logic [1:0] STG_ALE     = 2'd0;
    localparam logic [1:0] STG_SETTLE  = 2'd1;
    localparam logic [1:0] STG_STROBE  = 2'd2;
    localparam logic [1:0] STG_CAPTURE = 2'd3;

    // CPU addresses at or above this go to palette RAM, never to the VRAM bus.
    localparam logic [13:0] PALETTE_BASE_DEFAULT = 14'h3F00;

    // Address parked on the bus while nobody owns the slot.
    localparam logic [13:0] IDLE_ADDR_DEFAULT = 14'h0000;

    // True when a CPU address targets palette RAM.
    function automatic logic is_palette(input logic [13:0] addr, input logic [13:0] base);
        return addr >= base;
    endfunction

endpackage

// File: rtl/vram_stager.sv
// Free-running 2-bit memory stager and the bus strobe decode derived from it.
module vram_stager
    import ppu_vram_pkg::*;
(
    input  logic        clock_IN,
    input  logic        reset_IN,
    input  logic        clock_EN,
    input  slot_owner_t owner,
    input  logic        owner_write,
    output logic [1:0]  stage,
    output logic        ale,
    output logic        rd_n,
    output logic        wr_n,
    output logic        data_oe
);

    logic strobe_half;
    logic cpu_write_slot;
    logic reader_slot;

    // Advance one stage per PPU dot enable; wraps every four enables.
    always_ff @(posedge clock_IN) begin
        if (reset_IN) begin
            stage <= STG_ALE;
        end else if (clock_EN) begin
            stage <= stage + 2'd1;
        end
    end

    // Strobes follow directly from the stage and the slot owner.
    always_comb begin
        strobe_half    = (stage == STG_STROBE) || (stage == STG_CAPTURE);
        cpu_write_slot = (owner == CPU) && owner_write;
        reader_slot    = (owner == RENDER) || ((owner == CPU) && !owner_write);
        ale            = (stage == STG_ALE) && (owner != IDLE);
        rd_n           = !(strobe_half && reader_slot);
        wr_n           = !((stage == STG_STROBE) && cpu_write_slot);
        data_oe        = strobe_half && cpu_write_slot;
    end

endmodule

// File: rtl/vram_bus_scheduler.sv
// PPU VRAM bus scheduler: slot arbitration between render fetches and the
// CPU PPUDATA port, bus capture, and the CPU delayed read buffer.
module vram_bus_scheduler
    import ppu_vram_pkg::*;
#(
    parameter logic [13:0] PALETTE_BASE = PALETTE_BASE_DEFAULT,
    parameter logic [13:0] IDLE_ADDR    = IDLE_ADDR_DEFAULT
) (
    input  logic        clock_IN,
    input  logic        reset_IN,
    input  logic        clock_EN,
    input  logic        render_EN,
    input  logic        renderReq_IN,
    input  logic [13:0] renderAddr_IN,
    output logic        renderGrant_OUT,
    output logic [7:0]  renderData_OUT,
    output logic        renderValid_OUT,
    input  logic        cpuReq_IN,
    input  logic        cpuWrite_IN,
    input  logic [13:0] cpuAddr_IN,
    input  logic [7:0]  cpuData_IN,
    output logic        cpuBusy_OUT,
    output logic        cpuDone_OUT,
    output logic [7:0]  cpuReadBuf_OUT,
    output logic [1:0]  stage_OUT,
    output logic [13:0] busAddr_OUT,
    output logic [7:0]  busData_OUT,
    output logic        busDataOE_OUT,
    input  logic [7:0]  busData_IN,
    output logic        addressLatch_EN,
    output logic        read_EN,
    output logic        write_EN
);

    slot_owner_t owner;
    logic [13:0] slot_addr;
    logic        slot_write;

    logic        pending;
    logic        pend_write;
    logic [13:0] pend_addr;
    logic [7:0]  pend_data;

    logic [7:0]  read_buf;
    logic [7:0]  render_data;
    logic        grant_pulse;
    logic        valid_pulse;
    logic        done_pulse;

    logic [1:0]  stage;
    logic        slot_edge;
    logic        pend_palette;
    logic        cpu_eligible;

    // The last enable of a slot both captures data and decides the next owner.
    assign slot_edge    = clock_EN && (stage == STG_CAPTURE);
    assign pend_palette = pending && is_palette(pend_addr, PALETTE_BASE);
    // A CPU access finishing on this edge must not be granted a second slot.
    assign cpu_eligible = pending && !pend_palette && (owner != CPU);

    vram_stager u_stager (
        .clock_IN    (clock_IN),
        .reset_IN    (reset_IN),
        .clock_EN    (clock_EN),
        .owner       (owner),
        .owner_write (slot_write),
        .stage       (stage),
        .ale         (addressLatch_EN),
        .rd_n        (read_EN),
        .wr_n        (write_EN),
        .data_oe     (busDataOE_OUT)
    );

    // Pick the owner of the next slot: render first, then a non-palette CPU access.
    always_ff @(posedge clock_IN) begin
        if (reset_IN) begin
            owner       <= IDLE;
            slot_addr   <= IDLE_ADDR;
            slot_write  <= 1'b0;
            grant_pulse <= 1'b0;
        end else begin
            grant_pulse <= 1'b0;
            if (slot_edge) begin
                if (render_EN && renderReq_IN) begin
                    owner       <= RENDER;
                    slot_addr   <= renderAddr_IN;
                    slot_write  <= 1'b0;
                    grant_pulse <= 1'b1;
                end else if (cpu_eligible) begin
                    owner      <= CPU;
                    slot_addr  <= pend_addr;
                    slot_write <= pend_write;
                end else begin
                    owner      <= IDLE;
                    slot_addr  <= IDLE_ADDR;
                    slot_write <= 1'b0;
                end
            end
        end
    end

    // Single-entry CPU request holder, completion pulse and delayed read buffer.
    always_ff @(posedge clock_IN) begin
        if (reset_IN) begin
            pending    <= 1'b0;
            pend_write <= 1'b0;
            pend_addr  <= 14'h0000;
            pend_data  <= 8'h00;
            read_buf   <= 8'h00;
            done_pulse <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            if (slot_edge && (owner == CPU)) begin
                if (!slot_write) begin
                    read_buf <= busData_IN;
                end
                pending    <= 1'b0;
                done_pulse <= 1'b1;
            end else if (clock_EN && pend_palette) begin
                pending    <= 1'b0;
                done_pulse <= 1'b1;
            end else if (cpuReq_IN && !pending) begin
                pending    <= 1'b1;
                pend_write <= cpuWrite_IN;
                pend_addr  <= cpuAddr_IN;
                pend_data  <= cpuData_IN;
            end
        end
    end

    // Capture the render fetch byte at the end of a render slot.
    always_ff @(posedge clock_IN) begin
        if (reset_IN) begin
            render_data <= 8'h00;
            valid_pulse <= 1'b0;
        end else begin
            valid_pulse <= 1'b0;
            if (slot_edge && (owner == RENDER)) begin
                render_data <= busData_IN;
                valid_pulse <= 1'b1;
            end
        end
    end

    assign stage_OUT       = stage;
    assign busAddr_OUT     = slot_addr;
    assign busData_OUT     = pend_data;
    assign renderGrant_OUT = grant_pulse;
    assign renderValid_OUT = valid_pulse;
    assign renderData_OUT  = render_data;
    assign cpuBusy_OUT     = pending;
    assign cpuDone_OUT     = done_pulse;
    assign cpuReadBuf_OUT  = read_buf;

endmodule

// File: tb/tb_vram_bus_scheduler.sv
// Self-checking bench for vram_bus_scheduler with a slot-level reference model.
module tb_vram_bus_scheduler;

    logic        clock_IN = 1'b0;
    logic        reset_IN;
    logic        clock_EN;
    logic        render_EN;
    logic        renderReq_IN;
    logic [13:0] renderAddr_IN;
    logic        renderGrant_OUT;
    logic [7:0]  renderData_OUT;
    logic        renderValid_OUT;
    logic        cpuReq_IN;
    logic        cpuWrite_IN;
    logic [13:0] cpuAddr_IN;
    logic [7:0]  cpuData_IN;
    logic        cpuBusy_OUT;
    logic        cpuDone_OUT;
    logic [7:0]  cpuReadBuf_OUT;
    logic [1:0]  stage_OUT;
    logic [13:0] busAddr_OUT;
    logic [7:0]  busData_OUT;
    logic        busDataOE_OUT;
    logic [7:0]  busData_IN;
    logic        addressLatch_EN;
    logic        read_EN;
    logic        write_EN;

    int n_checks = 0;
    int n_fail   = 0;

    vram_bus_scheduler dut (
        .clock_IN        (clock_IN),
        .reset_IN        (reset_IN),
        .clock_EN        (clock_EN),
        .render_EN       (render_EN),
        .renderReq_IN    (renderReq_IN),
        .renderAddr_IN   (renderAddr_IN),
        .renderGrant_OUT (renderGrant_OUT),
        .renderData_OUT  (renderData_OUT),
        .renderValid_OUT (renderValid_OUT),
        .cpuReq_IN       (cpuReq_IN),
        .cpuWrite_IN     (cpuWrite_IN),
        .cpuAddr_IN      (cpuAddr_IN),
        .cpuData_IN      (cpuData_IN),
        .cpuBusy_OUT     (cpuBusy_OUT),
        .cpuDone_OUT     (cpuDone_OUT),
        .cpuReadBuf_OUT  (cpuReadBuf_OUT),
        .stage_OUT       (stage_OUT),
        .busAddr_OUT     (busAddr_OUT),
        .busData_OUT     (busData_OUT),
        .busDataOE_OUT   (busDataOE_OUT),
        .busData_IN      (busData_IN),
        .addressLatch_EN (addressLatch_EN),
        .read_EN         (read_EN),
        .write_EN        (write_EN)
    );

    // 10 ns system clock.
    always #5 clock_IN = ~clock_IN;

    // Dot enable on every fourth system clock, changed just after the rising edge.
    int en_cnt = 0;
    initial begin
        clock_EN = 1'b0;
        forever begin
            @(posedge clock_IN);
            #1;
            en_cnt++;
            clock_EN = (en_cnt % 4 == 0);
        end
    end

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            if (n_fail <= 40)
                $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: slot-level view of the bus (who holds the slot, what is queued).
    int          m_dots;
    int          m_owner;
    logic [13:0] m_addr;
    bit          m_wr;
    bit          m_pend;
    bit          m_pwr;
    logic [13:0] m_paddr;
    logic [7:0]  m_pdata;
    logic [7:0]  m_buf;
    logic [7:0]  m_rdata;
    bit          m_grant, m_valid, m_done;
    bit          m_live = 1'b0;

    // Model update: everything it needs is sampled at the same edge as the DUT.
    always @(posedge clock_IN) begin
        bit old_pend;
        int old_owner;
        int stg;
        if (reset_IN) begin
            m_live = 1'b1;
            m_dots = 0; m_owner = 0; m_addr = 14'h0; m_wr = 0;
            m_pend = 0; m_pwr = 0; m_paddr = 14'h0; m_pdata = 8'h0;
            m_buf = 8'h00; m_rdata = 8'h00;
            m_grant = 0; m_valid = 0; m_done = 0;
        end else if (m_live) begin
            old_pend  = m_pend;
            old_owner = m_owner;
            stg       = m_dots % 4;
            m_grant = 0; m_valid = 0; m_done = 0;
            if (clock_EN) begin
                m_dots = m_dots + 1;
                if (old_pend && m_paddr >= 14'h3F00) begin
                    m_pend = 0;
                    m_done = 1;
                end
                if (stg == 3) begin
                    if (old_owner == 1) begin
                        m_rdata = busData_IN;
                        m_valid = 1;
                    end
                    if (old_owner == 2) begin
                        if (!m_wr) m_buf = busData_IN;
                        m_pend = 0;
                        m_done = 1;
                    end
                    if (render_EN && renderReq_IN) begin
                        m_owner = 1; m_addr = renderAddr_IN; m_wr = 0; m_grant = 1;
                    end else if (old_pend && m_paddr < 14'h3F00 && old_owner != 2) begin
                        m_owner = 2; m_addr = m_paddr; m_wr = m_pwr;
                    end else begin
                        m_owner = 0;
                    end
                end
            end
            if (cpuReq_IN && !old_pend) begin
                m_pend = 1; m_pwr = cpuWrite_IN; m_paddr = cpuAddr_IN; m_pdata = cpuData_IN;
            end
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clock_IN) begin
        int stg;
        bit e_ale, e_rd, e_wr, e_oe;
        if (m_live) begin
            stg   = m_dots % 4;
            e_ale = (stg == 0) && (m_owner != 0);
            e_rd  = !((stg >= 2) && (m_owner == 1 || (m_owner == 2 && !m_wr)));
            e_wr  = !((stg == 2) && (m_owner == 2) && m_wr);
            e_oe  = (stg >= 2) && (m_owner == 2) && m_wr;
            checkOutput("stage", 32'(stage_OUT), 32'(stg));
            checkOutput("ale", 32'(addressLatch_EN), 32'(e_ale));
            checkOutput("read_n", 32'(read_EN), 32'(e_rd));
            checkOutput("write_n", 32'(write_EN), 32'(e_wr));
            checkOutput("data_oe", 32'(busDataOE_OUT), 32'(e_oe));
            checkOutput("bus_addr", 32'(busAddr_OUT), 32'((m_owner == 0) ? 14'h0 : m_addr));
            if (e_oe) checkOutput("bus_data", 32'(busData_OUT), 32'(m_pdata));
            checkOutput("render_grant", 32'(renderGrant_OUT), 32'(m_grant));
            checkOutput("render_valid", 32'(renderValid_OUT), 32'(m_valid));
            checkOutput("render_data", 32'(renderData_OUT), 32'(m_rdata));
            checkOutput("cpu_busy", 32'(cpuBusy_OUT), 32'(m_pend));
            checkOutput("cpu_done", 32'(cpuDone_OUT), 32'(m_done));
            checkOutput("read_buf", 32'(cpuReadBuf_OUT), 32'(m_buf));
        end
    end

    // Event counters used by the hand-computed expectations.
    int ale_cnt = 0, wr_low_cnt = 0, grant_cnt = 0, done_cnt = 0;
    always @(negedge clock_IN) begin
        if (addressLatch_EN === 1'b1) ale_cnt++;
        if (write_EN === 1'b0) wr_low_cnt++;
        if (renderGrant_OUT === 1'b1) grant_cnt++;
        if (cpuDone_OUT === 1'b1) done_cnt++;
    end

    // Issue one single-cycle PPUDATA request.
    task automatic applyStimulus(input bit wr, input logic [13:0] addr, input logic [7:0] data);
        @(posedge clock_IN); #1;
        cpuReq_IN = 1'b1; cpuWrite_IN = wr; cpuAddr_IN = addr; cpuData_IN = data;
        @(posedge clock_IN); #1;
        cpuReq_IN = 1'b0;
    endtask

    // Wait for the CPU completion pulse within a bounded number of clocks.
    task automatic waitDone(input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock_IN);
            if (cpuDone_OUT === 1'b1) seen = 1'b1;
        end
        checkOutput(name, 32'(seen), 32'd1);
    endtask

    initial begin
        bit hit;
        reset_IN = 1'b1; render_EN = 1'b0; renderReq_IN = 1'b0; renderAddr_IN = 14'h0;
        cpuReq_IN = 1'b0; cpuWrite_IN = 1'b0; cpuAddr_IN = 14'h0; cpuData_IN = 8'h0;
        busData_IN = 8'h00;
        repeat (5) @(posedge clock_IN);
        @(negedge clock_IN);
        checkOutput("reset_stage", 32'(stage_OUT), 32'd0);
        checkOutput("reset_read_n", 32'(read_EN), 32'd1);
        checkOutput("reset_write_n", 32'(write_EN), 32'd1);
        checkOutput("reset_buf", 32'(cpuReadBuf_OUT), 32'h00);

        // 1: stager free-runs with nothing owned
        @(posedge clock_IN); #1; reset_IN = 1'b0;
        ale_cnt = 0; wr_low_cnt = 0;
        repeat (20) @(negedge clock_IN);
        checkOutput("idle_ale_count", 32'(ale_cnt), 32'd0);
        checkOutput("idle_write_low", 32'(wr_low_cnt), 32'd0);

        // 2: CPU write A5 to 2000
        ale_cnt = 0; wr_low_cnt = 0;
        applyStimulus(1'b1, 14'h2000, 8'hA5);
        waitDone(60, "write_done");
        checkOutput("write_busy_after", 32'(cpuBusy_OUT), 32'd0);
        checkOutput("write_ale_clocks", 32'(ale_cnt), 32'd4);
        checkOutput("write_low_clocks", 32'(wr_low_cnt), 32'd4);

        // 3: two CPU reads fill the delayed buffer
        @(posedge clock_IN); #1; busData_IN = 8'h3C;
        applyStimulus(1'b0, 14'h2400, 8'h00);
        waitDone(60, "read1_done");
        checkOutput("read1_buf", 32'(cpuReadBuf_OUT), 32'h3C);
        @(posedge clock_IN); #1; busData_IN = 8'h77;
        applyStimulus(1'b0, 14'h2400, 8'h00);
        waitDone(60, "read2_done");
        checkOutput("read2_buf", 32'(cpuReadBuf_OUT), 32'h77);

        // 4: continuous render starves a CPU read until the request drops
        @(posedge clock_IN); #1;
        busData_IN = 8'h5A; render_EN = 1'b1; renderReq_IN = 1'b1; renderAddr_IN = 14'h1234;
        applyStimulus(1'b0, 14'h2800, 8'h00);
        grant_cnt = 0;
        repeat (64) @(negedge clock_IN);
        checkOutput("render_grants_64", 32'(grant_cnt), 32'd4);
        checkOutput("starved_busy", 32'(cpuBusy_OUT), 32'd1);
        checkOutput("render_byte", 32'(renderData_OUT), 32'h5A);
        @(posedge clock_IN); #1; renderReq_IN = 1'b0;
        waitDone(48, "unstarved_done");
        checkOutput("unstarved_buf", 32'(cpuReadBuf_OUT), 32'h5A);

        // 5: palette read completes at once even under render load
        @(posedge clock_IN); #1;
        busData_IN = 8'h99; renderReq_IN = 1'b1; renderAddr_IN = 14'h0ABC;
        applyStimulus(1'b0, 14'h3F05, 8'h00);
        waitDone(8, "palette_done");
        checkOutput("palette_buf", 32'(cpuReadBuf_OUT), 32'h5A);
        @(posedge clock_IN); #1; renderReq_IN = 1'b0; render_EN = 1'b0;
        repeat (20) @(negedge clock_IN);

        // 6: reset during the write strobe abandons the access
        applyStimulus(1'b1, 14'h2100, 8'h11);
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clock_IN);
            if (stage_OUT == 2'd2 && write_EN === 1'b0) hit = 1'b1;
        end
        checkOutput("reach_strobe", 32'(hit), 32'd1);
        reset_IN = 1'b1;
        @(posedge clock_IN); #1; reset_IN = 1'b0;
        @(negedge clock_IN);
        checkOutput("abort_write_n", 32'(write_EN), 32'd1);
        checkOutput("abort_stage", 32'(stage_OUT), 32'd0);
        checkOutput("abort_busy", 32'(cpuBusy_OUT), 32'd0);
        done_cnt = 0;
        repeat (40) @(negedge clock_IN);
        checkOutput("abort_no_done", 32'(done_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
